// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Round-robin owner selection for the shared memory-side buses (address,
//   data, result and the rd/wr strobes). Master 0 is the CPU and the rest
//   are auxiliary masters such as DMA engines or a debug port.
//
//   The registered one-hot grant also acts as each master's tri-state enable.
//   A dead turnaround cycle separates consecutive owners, so two drivers
//   never overlap on the bus.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   req        per-master request, held high until the master is finished
//   lock       owner's bit high prevents preemption
//   master_rd  per-master read strobe
//   master_wr  per-master write strobe
//   gnt        registered one-hot grant / bus output enable
//   gnt_id     index of the owner, valid while gnt_valid is high
//   gnt_valid  some master owns the bus
//   mem_rd     owner's read strobe routed to the memory port
//   mem_wr     owner's write strobe routed to the memory port
//   err        sticky protocol-error flag
module bus_arbiter #(
  parameter int N_MASTERS = 4,
  parameter int MAX_HOLD  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_MASTERS-1:0]         req,
  input  logic [N_MASTERS-1:0]         lock,
  input  logic [N_MASTERS-1:0]         master_rd,
  input  logic [N_MASTERS-1:0]         master_wr,
  output logic [N_MASTERS-1:0]         gnt,
  output logic [$clog2(N_MASTERS)-1:0] gnt_id,
  output logic                         gnt_valid,
  output logic                         mem_rd,
  output logic                         mem_wr,
  output logic                         err
);

  localparam int ID_W  = $clog2(N_MASTERS);
  localparam int CNT_W = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] PREEMPT_AT = CNT_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {IDLE, GRANT, TURN} state_t;

  state_t           state;
  logic [ID_W-1:0]  last;
  logic [CNT_W-1:0] hold_cnt;

  logic             win_found;
  logic [ID_W-1:0]  win_id;
  logic             owner_req;
  logic             owner_lock;
  logic             others_req;
  logic             collision;
  logic             stray;

  // Round-robin scan starting just after the previous owner. The previous
  // owner is visited last, which makes it the lowest-priority candidate.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 1; i <= N_MASTERS; i++) begin
      if (!win_found && req[(int'(last) + i) % N_MASTERS]) begin
        win_found = 1'b1;
        win_id    = ID_W'((int'(last) + i) % N_MASTERS);
      end
    end
  end

  // gnt is zero outside GRANT, so every masked term below is automatically
  // inactive when nobody owns the bus.
  always_comb begin
    owner_req  = req[gnt_id];
    owner_lock = lock[gnt_id];
    others_req = |(req & ~gnt);
    collision  = |(gnt & master_rd & master_wr);
    stray      = |((master_rd | master_wr) & ~gnt);
    mem_rd     = |(gnt & master_rd) & ~collision;
    mem_wr     = |(gnt & master_wr) & ~collision;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      err       <= 1'b0;
      last      <= ID_W'(N_MASTERS - 1);
      hold_cnt  <= '0;
    end else begin
      if (collision || stray) begin
        err <= 1'b1;
      end
      case (state)
        IDLE, TURN: begin
          if (win_found) begin
            state     <= GRANT;
            gnt       <= N_MASTERS'(1) << win_id;
            gnt_id    <= win_id;
            gnt_valid <= 1'b1;
            hold_cnt  <= '0;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (hold_cnt != CNT_MAX) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
          // The counter reads MAX_HOLD-1 on the MAX_HOLD-th edge after the
          // grant edge, so an unlocked owner keeps the bus exactly MAX_HOLD
          // cycles. A dropped request always releases, whatever lock says.
          if (!owner_req ||
              (hold_cnt >= PREEMPT_AT && !owner_lock && others_req)) begin
            state     <= TURN;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            last      <= gnt_id;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Directed bench for bus_arbiter with N_MASTERS=4 and MAX_HOLD=4.
//
//   A behavioural model tracks the owner, how many cycles it has held the bus,
//   and the previous owner. After every rising edge it predicts gnt,
//   gnt_valid, gnt_id, the strobes and err. Hand-computed checks at
//   key points of each scenario pin the model as well.
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int MH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req;
  logic [N-1:0] lock;
  logic [N-1:0] master_rd;
  logic [N-1:0] master_wr;
  logic [N-1:0] gnt;
  logic [1:0]   gnt_id;
  logic         gnt_valid;
  logic         mem_rd;
  logic         mem_wr;
  logic         err;

  int total = 0;
  int bad   = 0;
  bit checking = 1'b0;

  // Model state: owner index (-1 = bus free), cycles held, previous owner.
  int m_owner = -1;
  int m_held  = 0;
  int m_last  = N - 1;
  bit m_err   = 1'b0;

  bus_arbiter #(.N_MASTERS(N), .MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .master_rd (master_rd),
    .master_wr (master_wr),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual,
               expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] l,
                               input logic [N-1:0] rd, input logic [N-1:0] wr);
    req       = r;
    lock      = l;
    master_rd = rd;
    master_wr = wr;
  endtask

  function automatic int pickWinner(input logic [N-1:0] r, input int from);
    for (int k = 1; k <= N; k++) begin
      if (r[(from + k) % N]) return (from + k) % N;
    end
    return -1;
  endfunction

  // One edge of the model, using the inputs the DUT saw at that edge.
  // Arbitration happens only on an edge where nobody owns the bus. Because of
  // that, a release edge is always followed by one cycle with no owner.
  task automatic modelStep();
    logic [N-1:0] mine;
    int w;
    mine = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    if (((master_rd | master_wr) & ~mine) != '0) m_err = 1'b1;
    if ((master_rd & master_wr & mine) != '0) m_err = 1'b1;
    if (m_owner >= 0) begin
      if (!req[m_owner] ||
          (m_held >= MH && !lock[m_owner] && (req & ~mine) != '0)) begin
        m_last  = m_owner;
        m_owner = -1;
      end else begin
        m_held++;
      end
    end else begin
      w = pickWinner(req, m_last);
      if (w >= 0) begin
        m_owner = w;
        m_held  = 1;
      end
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1;
      m_held  = 0;
      m_last  = N - 1;
      m_err   = 1'b0;
    end else begin
      modelStep();
    end
  end

  task automatic compareModel();
    logic [N-1:0] exp_gnt;
    logic exp_rd;
    logic exp_wr;
    exp_gnt = '0;
    exp_rd  = 1'b0;
    exp_wr  = 1'b0;
    if (m_owner >= 0) begin
      exp_gnt = N'(1) << m_owner;
      if (!(master_rd[m_owner] && master_wr[m_owner])) begin
        exp_rd = master_rd[m_owner];
        exp_wr = master_wr[m_owner];
      end
    end
    checkOutput("model_gnt", gnt, exp_gnt);
    checkOutput("model_gnt_valid", gnt_valid, m_owner >= 0);
    if (m_owner >= 0) checkOutput("model_gnt_id", gnt_id, m_owner);
    checkOutput("model_mem_rd", mem_rd, exp_rd);
    checkOutput("model_mem_wr", mem_wr, exp_wr);
    checkOutput("model_err", err, m_err);
  endtask

  always @(posedge clk) begin
    #1;
    if (checking && !rst) compareModel();
  end

  initial begin
    rst = 1'b1;
    applyStimulus(4'b1111, '0, '0, '0);
    repeat (2) @(negedge clk);
    checkOutput("reset_gnt", gnt, 0);
    checkOutput("reset_gnt_valid", gnt_valid, 0);
    checkOutput("reset_gnt_id", gnt_id, 0);
    checkOutput("reset_mem_rd", mem_rd, 0);
    checkOutput("reset_mem_wr", mem_wr, 0);
    checkOutput("reset_err", err, 0);
    checking = 1'b1;

    // Reset release with all four requesting; each owner leaves after 3 cycles.
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      checkOutput("rr_gnt_start", gnt, 1 << i);
      checkOutput("rr_gnt_id", gnt_id, i);
      repeat (2) @(negedge clk);
      checkOutput("rr_gnt_third", gnt, 1 << i);
      req[i] = 1'b0;
      @(negedge clk);
      checkOutput("rr_dead_cycle", gnt, 0);
    end

    // Unlocked preemption after MAX_HOLD cycles.
    @(negedge clk);
    applyStimulus(4'b0010, '0, '0, '0);
    @(negedge clk);
    req[2] = 1'b1;
    checkOutput("pre_gnt1_c1", gnt, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("pre_gnt1_held", gnt, 4'b0010);
    end
    @(negedge clk);
    checkOutput("pre_dead", gnt, 0);
    @(negedge clk);
    checkOutput("pre_gnt2", gnt, 4'b0100);
    applyStimulus('0, '0, '0, '0);
    repeat (3) @(negedge clk);

    // Locked owner is not preempted; releases when its request drops.
    @(negedge clk);
    applyStimulus(4'b0010, 4'b0010, '0, '0);
    @(negedge clk);
    req[2] = 1'b1;
    checkOutput("lock_gnt1_c1", gnt, 4'b0010);
    repeat (9) @(negedge clk);
    checkOutput("lock_gnt1_c10", gnt, 4'b0010);
    req[1] = 1'b0;
    @(negedge clk);
    checkOutput("lock_dead", gnt, 0);
    @(negedge clk);
    checkOutput("lock_gnt2", gnt, 4'b0100);
    checkOutput("lock_gnt2_id", gnt_id, 2);
    applyStimulus('0, '0, '0, '0);
    repeat (3) @(negedge clk);

    // Sole requester keeps the bus, then drop and immediate re-request.
    @(negedge clk);
    applyStimulus(4'b0100, '0, '0, '0);
    repeat (41) @(negedge clk);
    checkOutput("sole_gnt_held", gnt, 4'b0100);
    req = '0;
    @(negedge clk);
    req = 4'b0100;
    checkOutput("sole_turn", gnt, 0);
    @(negedge clk);
    checkOutput("sole_regrant", gnt, 4'b0100);
    applyStimulus('0, '0, '0, '0);
    repeat (3) @(negedge clk);

    // Strobe muxing: owner write passes, non-owner read is blocked and flagged.
    @(negedge clk);
    applyStimulus(4'b1000, '0, '0, '0);
    @(negedge clk);
    checkOutput("strobe_gnt3", gnt, 4'b1000);
    master_wr = 4'b1000;
    #1;
    checkOutput("strobe_mem_wr", mem_wr, 1);
    checkOutput("strobe_mem_rd_idle", mem_rd, 0);
    @(negedge clk);
    master_wr = '0;
    checkOutput("strobe_err_clean", err, 0);
    @(negedge clk);
    master_rd = 4'b0001;
    #1;
    checkOutput("stray_mem_rd", mem_rd, 0);
    checkOutput("stray_err_before", err, 0);
    @(negedge clk);
    master_rd = '0;
    checkOutput("stray_err_set", err, 1);
    repeat (3) @(negedge clk);
    checkOutput("stray_err_sticky", err, 1);

    // Asynchronous reset in the middle of master 3's grant.
    master_wr = 4'b1000;
    #1;
    checkOutput("mid_mem_wr_before", mem_wr, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_gnt", gnt, 0);
    checkOutput("mid_rst_valid", gnt_valid, 0);
    checkOutput("mid_rst_mem_rd", mem_rd, 0);
    checkOutput("mid_rst_mem_wr", mem_wr, 0);
    checkOutput("mid_rst_err", err, 0);
    @(negedge clk);
    applyStimulus(4'b0100, '0, '0, '0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("mid_regrant", gnt, 4'b0100);
    checkOutput("mid_regrant_id", gnt_id, 2);

    // Owner rd/wr collision suppresses both strobes and sets err for good.
    master_rd = 4'b0100;
    master_wr = 4'b0100;
    #1;
    checkOutput("coll_mem_rd", mem_rd, 0);
    checkOutput("coll_mem_wr", mem_wr, 0);
    checkOutput("coll_err_before", err, 0);
    @(negedge clk);
    master_wr = '0;
    checkOutput("coll_err_set", err, 1);
    #1;
    checkOutput("coll_owner_rd_passes", mem_rd, 1);
    @(negedge clk);
    master_rd = '0;
    repeat (4) @(negedge clk);
    checkOutput("coll_err_sticky", err, 1);
    rst = 1'b1;
    #1;
    checkOutput("coll_err_cleared", err, 0);
    @(negedge clk);
    applyStimulus('0, '0, '0, '0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
